// File: rtl/equiv_check_sequencer_if.sv
// Handshake, stimulus and response bundle between the equivalence sequencer and its harness.
// With EQUIV_MISMATCH_CAPTURE_EN defined the bundle also carries the mismatch snapshot.
interface equiv_check_sequencer_if #(
  parameter int IN_W  = 76,
  parameter int Y_W   = 91,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [31:0]      seed;
  logic [IN_W-1:0]  stim;
  logic [Y_W-1:0]   y_1;
  logic [Y_W-1:0]   y_2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] fail_index;
`ifdef EQUIV_MISMATCH_CAPTURE_EN
  logic [IN_W-1:0]  cap_stim;
  logic [Y_W-1:0]   cap_y1;
  logic [Y_W-1:0]   cap_y2;
`endif

  modport slave (
    input  start, num_vectors, seed, y_1, y_2,
    output stim, busy, done, pass, vec_count, fail_index
`ifdef EQUIV_MISMATCH_CAPTURE_EN
    , output cap_stim, cap_y1, cap_y2
`endif
  );

  modport master (
    output start, num_vectors, seed, y_1, y_2,
    input  stim, busy, done, pass, vec_count, fail_index
`ifdef EQUIV_MISMATCH_CAPTURE_EN
    , input cap_stim, cap_y1, cap_y2
`endif
  );
endinterface

// File: rtl/equiv_check_sequencer.sv
// Bounded stimulus/compare sequencer for the dual-copy equivalence harness.
// Optional mismatch snapshot outputs are enabled by defining EQUIV_MISMATCH_CAPTURE_EN.
module equiv_check_sequencer #(
  parameter int IN_W   = 76,
  parameter int Y_W    = 91,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  equiv_check_sequencer_if.slave bus
);

  localparam logic [31:0]      LFSR_TAPS   = 32'h8020_0003;
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IN_W-1:0]  STIM_ZERO   = {IN_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_COMPARE = 3'd4
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = v[0] ? ((v >> 32'd1) ^ LFSR_TAPS) : (v >> 32'd1);
  endfunction

  state_t           state_r, state_nxt_s;
  logic             busy_r, done_r, pass_r;
  logic [31:0]      lfsr_r, seed_r, lfsr_nxt_s;
  logic [CNT_W-1:0] num_r, vec_count_r, fail_index_r, vec_inc_s;
  logic [7:0]       settle_cnt_r;
  logic [IN_W-1:0]  stim_r, stim_nxt_s;
  logic             match_s, last_s;
  logic             accept_s, load_s, drive_s, settle_s, cmp_s;

  assign lfsr_nxt_s = lfsr_step(lfsr_r);
  // Older words slide up; a 32-bit bus simply takes the new word.
  assign stim_nxt_s = (stim_r << 32'd32) | IN_W'(lfsr_nxt_s);
  assign match_s    = (bus.y_1 == bus.y_2);
  assign vec_inc_s  = vec_count_r + CNT_ONE;
  assign last_s     = (vec_inc_s == num_r);

  // State register; busy tracks the state being entered so it equals state != IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (num_r == CNT_ZERO) state_nxt_s = ST_IDLE;
        else                   state_nxt_s = ST_DRIVE;
      end
      ST_DRIVE: state_nxt_s = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) state_nxt_s = ST_COMPARE;
        else                             state_nxt_s = ST_SETTLE;
      end
      ST_COMPARE: begin
        if (!match_s)    state_nxt_s = ST_IDLE;
        else if (last_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_DRIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: one datapath strobe per state
  always_comb begin
    accept_s = 1'b0;
    load_s   = 1'b0;
    drive_s  = 1'b0;
    settle_s = 1'b0;
    cmp_s    = 1'b0;
    case (state_r)
      ST_IDLE:    accept_s = bus.start;
      ST_LOAD:    load_s   = 1'b1;
      ST_DRIVE:   drive_s  = 1'b1;
      ST_SETTLE:  settle_s = 1'b1;
      ST_COMPARE: cmp_s    = 1'b1;
      default:    accept_s = 1'b0;
    endcase
  end

  // Run datapath: request latches, LFSR and stimulus, counters and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r       <= 32'h0000_0001;
      seed_r       <= 32'h0000_0000;
      num_r        <= CNT_ZERO;
      stim_r       <= STIM_ZERO;
      vec_count_r  <= CNT_ZERO;
      fail_index_r <= CNT_ZERO;
      settle_cnt_r <= 8'd0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else if (accept_s) begin
      num_r  <= bus.num_vectors;
      seed_r <= bus.seed;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else if (load_s) begin
      lfsr_r       <= (seed_r == 32'h0000_0000) ? 32'h0000_0001 : seed_r;
      stim_r       <= STIM_ZERO;
      vec_count_r  <= CNT_ZERO;
      fail_index_r <= CNT_ZERO;
      if (num_r == CNT_ZERO) begin
        done_r <= 1'b1;
        pass_r <= 1'b1;
      end
    end else if (drive_s) begin
      lfsr_r       <= lfsr_nxt_s;
      stim_r       <= stim_nxt_s;
      settle_cnt_r <= 8'd0;
    end else if (settle_s) begin
      settle_cnt_r <= settle_cnt_r + 8'd1;
    end else if (cmp_s) begin
      if (!match_s) begin
        fail_index_r <= vec_count_r;
        pass_r       <= 1'b0;
        done_r       <= 1'b1;
      end else begin
        vec_count_r <= vec_inc_s;
        if (last_s) begin
          done_r <= 1'b1;
          pass_r <= 1'b1;
        end
      end
    end
  end

  assign bus.stim       = stim_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.vec_count  = vec_count_r;
  assign bus.fail_index = fail_index_r;

`ifdef EQUIV_MISMATCH_CAPTURE_EN
  logic [IN_W-1:0] cap_stim_r;
  logic [Y_W-1:0]  cap_y1_r, cap_y2_r;

  // Mismatch snapshot: cleared by an accepted start, loaded by the failing compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_stim_r <= STIM_ZERO;
      cap_y1_r   <= {Y_W{1'b0}};
      cap_y2_r   <= {Y_W{1'b0}};
    end else if (accept_s) begin
      cap_stim_r <= STIM_ZERO;
      cap_y1_r   <= {Y_W{1'b0}};
      cap_y2_r   <= {Y_W{1'b0}};
    end else if (cmp_s && !match_s) begin
      cap_stim_r <= stim_r;
      cap_y1_r   <= bus.y_1;
      cap_y2_r   <= bus.y_2;
    end
  end

  assign bus.cap_stim = cap_stim_r;
  assign bus.cap_y1   = cap_y1_r;
  assign bus.cap_y2   = cap_y2_r;
`endif

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Self-checking bench for equiv_check_sequencer: randomized runs against a run-level reference model.
module tb_equiv_check_sequencer;
  localparam int IN_W   = 76;
  localparam int Y_W    = 91;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;
  localparam int P      = SETTLE + 2;
  localparam int LIMIT  = 2000;
  localparam int NONE   = 9999;
  localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  equiv_check_sequencer_if #(.IN_W(IN_W), .Y_W(Y_W), .CNT_W(CNT_W)) bus ();
  equiv_check_sequencer #(.IN_W(IN_W), .Y_W(Y_W), .SETTLE(SETTLE), .CNT_W(CNT_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [IN_W-1:0] obs_stim [0:63];
  int   busy_cycles;
  int   end_t;
  logic done_early;

  function automatic logic [Y_W-1:0] rand_y();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[Y_W-1:0];
  endfunction

  // Reference: Galois right-shift LFSR, words shifted into the stimulus bus one per vector
  function automatic logic [IN_W-1:0] ref_stim(input logic [31:0] sd, input int k);
    logic [31:0] l;
    logic [IN_W-1:0] s;
    l = (sd == 32'd0) ? 32'd1 : sd;
    s = '0;
    for (int i = 0; i <= k; i++) begin
      l = (l >> 1) ^ ((l % 32'd2) == 32'd1 ? 32'h8020_0003 : 32'd0);
      s = (s << 32) | IN_W'(l);
    end
    return s;
  endfunction

  task automatic do_run(input logic [31:0] sd, input logic [CNT_W-1:0] n,
                        input int fail_at, input bit glitch);
    logic [Y_W-1:0] y;
    int k;
    @(negedge clk);
    bus.seed = sd; bus.num_vectors = n; bus.start = 1'b1;
    y = rand_y(); bus.y_1 = y; bus.y_2 = y;
    @(posedge clk);
    busy_cycles = 0; end_t = -1; done_early = 1'bx;
    for (int t = 1; t <= LIMIT; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (t == 2) done_early = bus.done;
      if (bus.busy === 1'b1) busy_cycles++;
      else begin
        end_t = t - 1;
        break;
      end
      if (glitch && t == 6) begin
        bus.start = 1'b1; bus.seed = ~sd; bus.num_vectors = n + 16'd3;
      end
      y = rand_y(); bus.y_1 = y; bus.y_2 = y;
      if (t >= SETTLE + 3 && (t - SETTLE - 3) % P == 0) begin
        k = (t - SETTLE - 3) / P;
        if (k < 64) obs_stim[k] = bus.stim;
        if (k == fail_at) bus.y_2 = y ^ Y_ONE;
      end
    end
    bus.start = 1'b0;
    bus.y_2 = bus.y_1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.num_vectors = '0; bus.seed = '0;
    bus.y_1 = '0; bus.y_2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", bus.pass); end
    checks++; if (bus.stim !== '0) begin failures++; $display("FAIL reset_stim got=%h exp=0", bus.stim); end
    checks++; if (bus.vec_count !== '0) begin failures++; $display("FAIL reset_vec_count got=%0d exp=0", bus.vec_count); end
    checks++; if (bus.fail_index !== '0) begin failures++; $display("FAIL reset_fail_index got=%0d exp=0", bus.fail_index); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pass();
    logic [IN_W-1:0] first_exp;
    first_exp = 76'h0_0000_0000_8020_0003;
    do_run(32'd1, 16'd4, NONE, 1'b0);
    checks++; if (obs_stim[0] !== first_exp) begin failures++; $display("FAIL basic_first_stim got=%h exp=%h", obs_stim[0], first_exp); end
    checks++; if (obs_stim[3] !== ref_stim(32'd1, 3)) begin failures++; $display("FAIL basic_stim3 got=%h exp=%h", obs_stim[3], ref_stim(32'd1, 3)); end
    checks++; if (busy_cycles != 17) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=17", busy_cycles); end
    checks++; if (end_t != 17) begin failures++; $display("FAIL basic_end got=%0d exp=17", end_t); end
    checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin failures++; $display("FAIL basic_result got done=%0b pass=%0b exp 1/1", bus.done, bus.pass); end
    checks++; if (bus.vec_count !== 16'd4) begin failures++; $display("FAIL basic_vec_count got=%0d exp=4", bus.vec_count); end
    checks++; if (bus.fail_index !== 16'd0) begin failures++; $display("FAIL basic_fail_index got=%0d exp=0", bus.fail_index); end
  endtask

  task automatic test_first_mismatch();
    logic [31:0] sd;
    sd = $urandom();
    do_run(sd, 16'd10, 2, 1'b0);
    checks++; if (done_early !== 1'b0) begin failures++; $display("FAIL mm_done_cleared got=%0b exp=0", done_early); end
    checks++; if (end_t != SETTLE + 3 + 2 * P) begin failures++; $display("FAIL mm_end got=%0d exp=%0d", end_t, SETTLE + 3 + 2 * P); end
    checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b0) begin failures++; $display("FAIL mm_result got done=%0b pass=%0b exp 1/0", bus.done, bus.pass); end
    checks++; if (bus.fail_index !== 16'd2) begin failures++; $display("FAIL mm_fail_index got=%0d exp=2", bus.fail_index); end
    checks++; if (bus.vec_count !== 16'd2) begin failures++; $display("FAIL mm_vec_count got=%0d exp=2", bus.vec_count); end
    checks++; if (obs_stim[2] !== ref_stim(sd, 2)) begin failures++; $display("FAIL mm_stim2 got=%h exp=%h", obs_stim[2], ref_stim(sd, 2)); end
`ifdef EQUIV_MISMATCH_CAPTURE_EN
    checks++; if (bus.cap_stim !== ref_stim(sd, 2)) begin failures++; $display("FAIL cap_stim got=%h exp=%h", bus.cap_stim, ref_stim(sd, 2)); end
    checks++; if ((bus.cap_y1 ^ bus.cap_y2) !== Y_ONE) begin failures++; $display("FAIL cap_xor got=%h exp=1", bus.cap_y1 ^ bus.cap_y2); end
`endif
  endtask

  task automatic test_zero_and_seed0();
    do_run($urandom(), 16'd0, NONE, 1'b0);
    checks++; if (end_t != 1) begin failures++; $display("FAIL zero_end got=%0d exp=1", end_t); end
    checks++; if (busy_cycles != 1) begin failures++; $display("FAIL zero_busy got=%0d exp=1", busy_cycles); end
    checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin failures++; $display("FAIL zero_result got done=%0b pass=%0b exp 1/1", bus.done, bus.pass); end
    checks++; if (bus.vec_count !== 16'd0 || bus.stim !== '0) begin failures++; $display("FAIL zero_cleared got vec=%0d stim=%h exp 0/0", bus.vec_count, bus.stim); end
`ifdef EQUIV_MISMATCH_CAPTURE_EN
    checks++; if (bus.cap_stim !== '0 || bus.cap_y1 !== '0 || bus.cap_y2 !== '0) begin failures++; $display("FAIL cap_clear got stim=%h y1=%h y2=%h exp 0", bus.cap_stim, bus.cap_y1, bus.cap_y2); end
`endif
    do_run(32'd0, 16'd1, NONE, 1'b0);
    checks++; if (obs_stim[0] !== ref_stim(32'd1, 0)) begin failures++; $display("FAIL seed0_stim got=%h exp=%h", obs_stim[0], ref_stim(32'd1, 0)); end
    checks++; if (end_t != SETTLE + 3 || bus.pass !== 1'b1) begin failures++; $display("FAIL seed0_run got end=%0d pass=%0b exp %0d/1", end_t, bus.pass, SETTLE + 3); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] sd;
    sd = $urandom();
    do_run(sd, 16'd10, NONE, 1'b1);
    checks++; if (end_t != SETTLE + 3 + 9 * P) begin failures++; $display("FAIL busy_start_end got=%0d exp=%0d", end_t, SETTLE + 3 + 9 * P); end
    checks++; if (bus.vec_count !== 16'd10 || bus.pass !== 1'b1) begin failures++; $display("FAIL busy_start_result got vec=%0d pass=%0b exp 10/1", bus.vec_count, bus.pass); end
    checks++; if (obs_stim[9] !== ref_stim(sd, 9)) begin failures++; $display("FAIL busy_start_stim got=%h exp=%h", obs_stim[9], ref_stim(sd, 9)); end
  endtask

  task automatic test_random();
    logic [31:0] sd;
    int nn, fa, cmpn;
    bit pass_e;
    for (int r = 0; r < 8; r++) begin
      sd = $urandom(); nn = $urandom_range(1, 8); fa = $urandom_range(0, 10);
      pass_e = (fa >= nn);
      cmpn = pass_e ? nn : fa + 1;
      do_run(sd, CNT_W'(nn), fa, 1'b0);
      checks++; if (end_t != SETTLE + 3 + (cmpn - 1) * P) begin failures++; $display("FAIL rand_end run=%0d got=%0d exp=%0d", r, end_t, SETTLE + 3 + (cmpn - 1) * P); end
      checks++; if (bus.done !== 1'b1 || bus.pass !== pass_e) begin failures++; $display("FAIL rand_result run=%0d got done=%0b pass=%0b exp 1/%0b", r, bus.done, bus.pass, pass_e); end
      checks++; if (bus.vec_count !== CNT_W'(pass_e ? nn : fa)) begin failures++; $display("FAIL rand_vec_count run=%0d got=%0d exp=%0d", r, bus.vec_count, pass_e ? nn : fa); end
      checks++; if (bus.fail_index !== CNT_W'(pass_e ? 0 : fa)) begin failures++; $display("FAIL rand_fail_index run=%0d got=%0d exp=%0d", r, bus.fail_index, pass_e ? 0 : fa); end
      for (int k = 0; k < cmpn; k++) begin
        checks++; if (obs_stim[k] !== ref_stim(sd, k)) begin failures++; $display("FAIL rand_stim run=%0d vec=%0d got=%h exp=%h", r, k, obs_stim[k], ref_stim(sd, k)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.seed = $urandom(); bus.num_vectors = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin failures++; $display("FAIL midrst_flags got busy=%0b done=%0b pass=%0b exp 0", bus.busy, bus.done, bus.pass); end
    checks++; if (bus.stim !== '0 || bus.vec_count !== '0 || bus.fail_index !== '0) begin failures++; $display("FAIL midrst_data got stim=%h vec=%0d idx=%0d exp 0", bus.stim, bus.vec_count, bus.fail_index); end
`ifdef EQUIV_MISMATCH_CAPTURE_EN
    checks++; if (bus.cap_stim !== '0 || bus.cap_y1 !== '0 || bus.cap_y2 !== '0) begin failures++; $display("FAIL midrst_cap got nonzero capture"); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL midrst_idle got busy=%0b done=%0b exp 0/0", bus.busy, bus.done); end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_first_mismatch();
    test_zero_and_seed0();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/equiv_check_sequencer.md
Name: equiv_check_sequencer

Overview:
- Self-checking stimulus sequencer for the dual-copy equivalence harness.
- Drives one pseudo-random input vector to both design copies, waits a settle window, then compares their outputs y_1 and y_2.
- Counts the vectors that pass and stops on the first mismatch.
- Reports the result through a start/busy/done handshake.
- Replaces the free-running assert with a bounded, observable run, so the harness can be simulated or emulated without a formal tool.

Parameters:
- IN_W, 76, width of the concatenated DUT input bus (wire4..wire0). Must be >= 32.
- Y_W, 91, width of each DUT output (y_1, y_2).
- SETTLE, 2, cycles between driving a vector and comparing. Legal range 1..255.
- CNT_W, 16, width of the vector count and index fields.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a run. Ignored while busy=1.
- num_vectors  input  CNT_W  number of vectors to apply. Sampled when start is accepted.
- seed  input  32  LFSR seed. Sampled when start is accepted. Value 0 is replaced by 32'h1.
- stim  output  IN_W  shared stimulus bus to both DUT copies.
- y_1  input  Y_W  output of copy 1.
- y_2  input  Y_W  output of copy 2.
- busy  output  1  high from the LOAD state through the last COMPARE cycle.
- done  output  1  sticky. Set when a run ends; cleared when the next start is accepted.
- pass  output  1  valid while done=1. 1 means all vectors matched.
- vec_count  output  CNT_W  number of vectors compared and matched.
- fail_index  output  CNT_W  index of the first mismatching vector (0-based). Holds 0 if the run passed.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, lfsr=32'h1, stim=0.
  - busy=0, done=0, pass=0, vec_count=0, fail_index=0, settle counter=0.
- FSM states: IDLE, LOAD, DRIVE, SETTLE, COMPARE.
- IDLE:
  - start=1 → LOAD. num_vectors and seed are latched; done and pass are cleared.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - lfsr <= seed, or 32'h1 if seed==0.
  - stim <= 0, vec_count <= 0, fail_index <= 0.
  - If the latched num_vectors==0: go to IDLE, set done=1 and pass=1.
  - Otherwise → DRIVE.
- DRIVE (1 cycle):
  - LFSR steps once: Galois, right-shift, taps 32'h80200003. If lsb=1, next = (lfsr>>1) ^ 32'h80200003; else next = lfsr>>1.
  - stim <= {stim[IN_W-33:0], next_lfsr}.
  - Settle counter <= 0. → SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - When the counter reaches SETTLE-1 → COMPARE. This gives exactly SETTLE cycles.
- COMPARE (1 cycle):
  - If y_1 != y_2: fail_index <= vec_count, pass <= 0, done <= 1 → IDLE.
  - If equal: vec_count <= vec_count+1.
    - If vec_count+1 == num_vectors: done <= 1, pass <= 1 → IDLE.
    - Otherwise → DRIVE.
- Timing and handshake:
  - Per-vector period is SETTLE+2 cycles.
  - First compare occurs SETTLE+3 cycles after start is accepted.
  - busy is a registered output of the state (busy = state != IDLE).
  - stim holds its last value after a run ends; it is not cleared until the next LOAD.
- Boundary conditions:
  - start while busy=1 is ignored. No restart and no re-latching.
  - start in the same cycle that done is set is ignored; start is only sampled in IDLE.
  - vec_count cannot wrap, because num_vectors <= 2^CNT_W-1.
  - rst_n asserted mid-run aborts immediately to reset values. done stays 0.
- The comparison uses combinational equality on the full Y_W bits; X/Z handling is simulator-defined.

Optional Feature:
- Macro: EQUIV_MISMATCH_CAPTURE_EN.
- Defined:
  - Adds outputs cap_stim (IN_W), cap_y1 (Y_W) and cap_y2 (Y_W).
  - On the first mismatch in COMPARE they load stim, y_1 and y_2.
  - They hold until the next accepted start, which clears them to 0. Reset value is 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 3 cycles → busy=0, done=0, pass=0, stim=0, vec_count=0.
- Basic pass: seed=1, num_vectors=4, y_2 tied to y_1 → first stim = 76'h0_0000_0000_8020_0003. done=1, pass=1, vec_count=4, busy high for exactly 1+4*(SETTLE+2)=17 cycles.
- First mismatch: num_vectors=10, force y_2=y_1^1 only during the 3rd COMPARE → done=1, pass=0, fail_index=2, vec_count=2.
- Zero vectors and seed=0: start with num_vectors=0 → done=1, pass=1 two cycles after start. seed=0 with num_vectors=1 → first stim equals the seed=1 case.
- Handshake robustness: pulse start mid-run with different num_vectors/seed → run completes using the original values. Deassert rst_n mid-SETTLE → all outputs return to reset values asynchronously.
- With EQUIV_MISMATCH_CAPTURE_EN: repeat the mismatch test → cap_stim equals stim at vector 2, cap_y1^cap_y2 = 1. A new start clears all three capture outputs to 0.
